osd_writer: RTL and testbench

Write-port controller for the OSD text screen buffer. Two requesters (channel 0: host/menu logic, channel 1: status-line updater) issue commands over a req/ack handshake. The block arbitrates between them round-robin, keeps a per-channel cursor and invert attribute, and drives the text buffer's `address`/`data`/`wren` write port. It also runs a full-screen clear engine. It sits between the OSD control logic and the text-mode renderer's buffer write port.

---
 rtl/osd_pkg.sv | 22 ++
 rtl/osd_rr_arbiter.sv | 28 ++
 rtl/osd_writer.sv | 176 +++++++++++++++++
 tb/tb_osd_writer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared types and defaults for the OSD text-buffer write port.
package osd_pkg;

  localparam int DEF_WINDOW_W = 32;
  localparam int DEF_WINDOW_H = 8;
  localparam int DEF_ADDR_W   = 8;

  localparam logic [7:0] NEWLINE = 8'h0A;

  typedef enum logic [1:0] {
    CMD_PUTC    = 2'd0,
    CMD_GOTO    = 2'd1,
    CMD_CLEAR   = 2'd2,
    CMD_SETATTR = 2'd3
  } cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/osd_rr_arbiter.sv
// Two-way round-robin arbiter; on a tie the channel not granted last wins.
module osd_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic lastGrant_q, lastGrant_d;

  always_comb begin
    grant       = 2'b00;
    lastGrant_d = lastGrant_q;
    if (enable) begin
      if (req == 2'b11) grant = lastGrant_q ? 2'b01 : 2'b10;
      else              grant = req;
    end
    if (|grant) lastGrant_d = grant[1];
  end

  // Pointer resets to channel 1 so channel 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) lastGrant_q <= 1'b1;
    else       lastGrant_q <= lastGrant_d;
  end

endmodule

// File: rtl/osd_writer.sv
// OSD text-buffer write-port controller: two arbitrated command channels,
// per-channel cursor/invert attribute and a full-screen clear engine.
module osd_writer
  import osd_pkg::*;
#(
  parameter int WINDOW_W = DEF_WINDOW_W,
  parameter int WINDOW_H = DEF_WINDOW_H,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        cmd0,
  input  logic [1:0]        cmd1,
  input  logic [7:0]        arg0,
  input  logic [7:0]        arg1,
  output logic              ack0,
  output logic              ack1,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        data,
  output logic              wren,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WINDOW_W * WINDOW_H - 1);
  localparam logic [ADDR_W-1:0] ROW_MASK  = ADDR_W'(WINDOW_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(WINDOW_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur0_q, cur0_d, cur1_q, cur1_d;
  logic                inv0_q, inv0_d, inv1_q, inv1_d;
  logic [ADDR_W-1:0]   clrCnt_q, clrCnt_d;
  logic [7:0]          clrData_q, clrData_d;
  logic                clrCh_q, clrCh_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                wren_q, wren_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                busy_q, busy_d;

  logic [1:0]          grant;
  cmd_e                selCmd;
  logic [7:0]          selArg;
  logic [ADDR_W-1:0]   selCur, newCur;
  logic                selInv, newInv;

  osd_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .enable (state_q == ST_IDLE),
    .grant  (grant)
  );

  always_comb begin
    state_d   = state_q;
    cur0_d    = cur0_q;
    cur1_d    = cur1_q;
    inv0_d    = inv0_q;
    inv1_d    = inv1_q;
    clrCnt_d  = clrCnt_q;
    clrData_d = clrData_q;
    clrCh_d   = clrCh_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    busy_d    = busy_q;
    selCmd    = grant[1] ? cmd_e'(cmd1) : cmd_e'(cmd0);
    selArg    = grant[1] ? arg1 : arg0;
    selCur    = grant[1] ? cur1_q : cur0_q;
    selInv    = grant[1] ? inv1_q : inv0_q;
    newCur    = selCur;
    newInv    = selInv;

    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          ack0_d = grant[0];
          ack1_d = grant[1];
          case (selCmd)
            CMD_PUTC: begin
              if (selArg == NEWLINE) begin
                newCur = (selCur & ~ROW_MASK) + ROW_STEP;
              end else begin
                wren_d = 1'b1;
                addr_d = selCur;
                data_d = {selArg[7] | selInv, selArg[6:0]};
                newCur = selCur + 1'b1;
              end
            end
            CMD_GOTO:    newCur = selArg[ADDR_W-1:0];
            CMD_SETATTR: newInv = selArg[0];
            CMD_CLEAR: begin
              // Ack is deferred until the final clear write.
              ack0_d    = 1'b0;
              ack1_d    = 1'b0;
              wren_d    = 1'b1;
              addr_d    = '0;
              data_d    = selArg;
              clrData_d = selArg;
              clrCnt_d  = ADDR_W'(1);
              clrCh_d   = grant[1];
              busy_d    = 1'b1;
              newCur    = '0;
              state_d   = ST_CLEAR;
            end
          endcase
          if (grant[1]) begin
            cur1_d = newCur;
            inv1_d = newInv;
          end else begin
            cur0_d = newCur;
            inv0_d = newInv;
          end
        end
      end
      ST_CLEAR: begin
        wren_d   = 1'b1;
        addr_d   = clrCnt_q;
        data_d   = clrData_q;
        clrCnt_d = clrCnt_q + 1'b1;
        if (clrCnt_q == LAST_ADDR) begin
          ack0_d  = ~clrCh_q;
          ack1_d  = clrCh_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cur0_q    <= '0;
      cur1_q    <= '0;
      inv0_q    <= 1'b0;
      inv1_q    <= 1'b0;
      clrCnt_q  <= '0;
      clrData_q <= '0;
      clrCh_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur0_q    <= cur0_d;
      cur1_q    <= cur1_d;
      inv0_q    <= inv0_d;
      inv1_q    <= inv1_d;
      clrCnt_q  <= clrCnt_d;
      clrData_q <= clrData_d;
      clrCh_q   <= clrCh_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
    end
  end

  assign address = addr_q;
  assign data    = data_q;
  assign wren    = wren_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_osd_writer.sv
// Table-driven and scoreboard bench for osd_writer.
module tb_osd_writer;

  localparam logic [1:0] PUTC    = 2'd0;
  localparam logic [1:0] GOTO    = 2'd1;
  localparam logic [1:0] CLEAR   = 2'd2;
  localparam logic [1:0] SETATTR = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [1:0] cmd0, cmd1;
  logic [7:0] arg0, arg1;
  logic       ack0, ack1;
  logic [7:0] address;
  logic [7:0] data;
  logic       wren;
  logic       busy;

  osd_writer dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .cmd0    (cmd0),
    .cmd1    (cmd1),
    .arg0    (arg0),
    .arg1    (arg1),
    .ack0    (ack0),
    .ack1    (ack1),
    .address (address),
    .data    (data),
    .wren    (wren),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [1:0] cmd;
    logic [7:0] arg;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] dat;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] dat;
    logic [1:0] ack;
    logic       busy;
    int         gap;
  } wrExp_t;

  vec_t   vec[23];
  wrExp_t expQ[$];
  wrExp_t monE;
  int     ackLog[$];
  bit     logAcks = 1'b0;
  int     nChecks = 0;
  int     nPass   = 0;
  int     cycle   = 0;
  int     lastWr  = -1000;
  int     lat, lat0, lat1, dummy0, dummy1;
  bit     found;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cycle++;

  // Scoreboard: every write must match the front of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack0 | ack1) begin
        checkVal("ackExclusive", {31'b0, ack0 & ack1}, 32'd0);
        if (logAcks) ackLog.push_back(ack1 ? 1 : 0);
      end
      if (wren) begin
        if (expQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL unexpectedWrite: got addr=%0h data=%0h, expected no write", address, data);
        end else begin
          monE = expQ.pop_front();
          checkVal("wrAddr", {24'b0, address}, {24'b0, monE.addr});
          checkVal("wrData", {24'b0, data}, {24'b0, monE.dat});
          checkVal("wrAck", {30'b0, ack1, ack0}, {30'b0, monE.ack});
          checkVal("wrBusy", {31'b0, busy}, {31'b0, monE.busy});
          if (monE.gap >= 0) checkVal("wrGap", cycle - lastWr, monE.gap);
        end
        lastWr = cycle;
      end
    end
  end

  task automatic send(input int ch, input logic [1:0] c, input logic [7:0] a, output int latency);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    if (ch == 0) begin req0 = 1'b1; cmd0 = c; arg0 = a; end
    else         begin req1 = 1'b1; cmd1 = c; arg1 = a; end
    latency = 0;
    while (!got && latency < 400) begin
      @(negedge clk);
      latency++;
      if ((ch == 0 && ack0) || (ch == 1 && ack1)) got = 1'b1;
    end
    if (ch == 0) req0 = 1'b0;
    else         req1 = 1'b0;
    if (!got) begin
      nChecks++;
      $display("[TB] FAIL ackTimeout ch%0d: got no ack, expected ack within 400 cycles", ch);
    end
  endtask

  task automatic applyStimulus(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vec[i].wr)
        expQ.push_back('{vec[i].addr, vec[i].dat, (vec[i].ch == 0) ? 2'b01 : 2'b10, 1'b0, -1});
      send(vec[i].ch, vec[i].cmd, vec[i].arg, lat);
      checkVal($sformatf("latency[%0d]", i), lat, 32'd2);
      #1;
      checkVal($sformatf("writeDone[%0d]", i), expQ.size(), 32'd0);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".address"}, {24'b0, address}, 32'd0);
    checkVal({tag, ".data"}, {24'b0, data}, 32'd0);
    checkVal({tag, ".wren"}, {31'b0, wren}, 32'd0);
    checkVal({tag, ".ack0"}, {31'b0, ack0}, 32'd0);
    checkVal({tag, ".ack1"}, {31'b0, ack1}, 32'd0);
    checkVal({tag, ".busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected completion before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec[0]  = '{0, PUTC,    8'h41, 1'b1, 8'h00, 8'h41};
    vec[1]  = '{0, PUTC,    8'h41, 1'b1, 8'h01, 8'h41};
    vec[2]  = '{0, PUTC,    8'h41, 1'b1, 8'h02, 8'h41};
    vec[3]  = '{0, SETATTR, 8'h01, 1'b0, 8'h00, 8'h00};
    vec[4]  = '{0, GOTO,    8'hFF, 1'b0, 8'h00, 8'h00};
    vec[5]  = '{0, PUTC,    8'h05, 1'b1, 8'hFF, 8'h85};
    vec[6]  = '{0, PUTC,    8'h06, 1'b1, 8'h00, 8'h86};
    vec[7]  = '{1, GOTO,    8'h23, 1'b0, 8'h00, 8'h00};
    vec[8]  = '{1, PUTC,    8'h0A, 1'b0, 8'h00, 8'h00};
    vec[9]  = '{1, PUTC,    8'h11, 1'b1, 8'h40, 8'h11};
    vec[10] = '{1, GOTO,    8'hE5, 1'b0, 8'h00, 8'h00};
    vec[11] = '{1, PUTC,    8'h0A, 1'b0, 8'h00, 8'h00};
    vec[12] = '{1, PUTC,    8'h12, 1'b1, 8'h00, 8'h12};
    vec[13] = '{0, PUTC,    8'h07, 1'b1, 8'h01, 8'h87};
    vec[14] = '{1, PUTC,    8'h85, 1'b1, 8'h01, 8'h85};
    vec[15] = '{0, GOTO,    8'h00, 1'b0, 8'h00, 8'h00};
    vec[16] = '{1, GOTO,    8'h80, 1'b0, 8'h00, 8'h00};
    vec[17] = '{0, PUTC,    8'h42, 1'b1, 8'h00, 8'hC2};
    vec[18] = '{1, SETATTR, 8'h01, 1'b0, 8'h00, 8'h00};
    vec[19] = '{1, PUTC,    8'h62, 1'b1, 8'h85, 8'hE2};
    vec[20] = '{1, PUTC,    8'h44, 1'b1, 8'h00, 8'h44};
    vec[21] = '{0, PUTC,    8'h0A, 1'b0, 8'h00, 8'h00};
    vec[22] = '{0, PUTC,    8'h45, 1'b1, 8'h20, 8'h45};

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    cmd0 = 2'd0; cmd1 = 2'd0;
    arg0 = 8'h00; arg1 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(0, 16);

    // Both channels stream PUTCs; grants must alternate starting with ch0.
    for (int i = 0; i < 4; i++) begin
      expQ.push_back('{8'(i), 8'(8'hB0 + i), 2'b01, 1'b0, (i == 0) ? -1 : 1});
      expQ.push_back('{8'(8'h80 + i), 8'(8'h50 + i), 2'b10, 1'b0, 1});
    end
    logAcks = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, PUTC, 8'(8'h30 + i), dummy0);
      end
      begin
        for (int i = 0; i < 4; i++) send(1, PUTC, 8'(8'h50 + i), dummy1);
      end
    join
    #1;
    logAcks = 1'b0;
    checkVal("altAckCount", ackLog.size(), 32'd8);
    for (int i = 0; i < 8 && i < ackLog.size(); i++)
      checkVal($sformatf("altGrant[%0d]", i), ackLog[i], i % 2);
    checkVal("altQueueEmpty", expQ.size(), 32'd0);

    // Clear by ch0 while ch1 holds a PUTC; ch1 is served right after.
    for (int i = 0; i < 256; i++)
      expQ.push_back('{8'(i), 8'h20, (i == 255) ? 2'b01 : 2'b00, (i != 255), (i == 0) ? -1 : 1});
    expQ.push_back('{8'h84, 8'h61, 2'b10, 1'b0, 1});
    fork
      send(0, CLEAR, 8'h20, lat0);
      send(1, PUTC, 8'h61, lat1);
    join
    checkVal("clearAckLatency", lat0, 32'd257);
    checkVal("waitPutcLatency", lat1, 32'd258);
    #1;
    checkVal("clearQueueEmpty", expQ.size(), 32'd0);

    applyStimulus(17, 19);

    // Reset during a clear aborts it with no ack.
    for (int i = 0; i <= 100; i++)
      expQ.push_back('{8'(i), 8'h55, 2'b00, 1'b1, (i == 0) ? -1 : 1});
    @(posedge clk);
    #1;
    req0 = 1'b1; cmd0 = CLEAR; arg0 = 8'h55;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (wren && address == 8'd100) found = 1'b1;
    end
    #1;
    reset = 1'b1;
    req0 = 1'b0;
    checkVal("clearReachedWrite100", {31'b0, found}, 32'd1);
    @(negedge clk);
    checkOutput("midClearReset");
    checkVal("abortQueueEmpty", expQ.size(), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(20, 22);

    repeat (3) @(negedge clk);
    checkVal("finalQueueEmpty", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
